clz_div: RTL and testbench
==========================

Name: clz_div

Overview:
- Multi-cycle 32-bit integer divider for the DIV and DIVU instructions. Sits downstream of the count-leading-zeros unit.
- Instantiates _CLZ on |dividend| and pre-shifts the dividend past its leading zeros. Only 32-clz restoring iterations run, so small operands finish early.
- Results go to the HI/LO write path. The pipeline stalls on busy.

Parameters:
DIV0_Q, 32'hFFFFFFFF, quotient returned on divide-by-zero
DIV0_R_IS_DIVIDEND, 1, when 1 the remainder on divide-by-zero equals the dividend; when 0 it is 0

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  request; sampled only while idle
is_signed  in  1  1=DIV, 0=DIVU; sampled with start
dividend  in  32  sampled with start
divisor  in  32  sampled with start
busy  out  1  high from the edge that accepts start until done falls
done  out  1  one-cycle pulse; q/r valid from this cycle on
q  out  32  quotient (to LO)
r  out  32  remainder (to HI)

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; busy=0, done=0, q=0, r=0; all internal registers cleared. Reset mid-operation abandons the division with no further done.
- States: IDLE, RUN, FIN.
- IDLE, start=1, accepted at edge E0:
  - Capture sign_q = is_signed & (dividend[31]^divisor[31]) and sign_r = is_signed & dividend[31].
  - Capture ad = |dividend| and bd = |divisor|; the absolute value is taken only when is_signed, otherwise the raw value.
  - Set n = 32 - clz(ad), 6 bits, range 0..32.
  - Set quo = ad << clz(ad) (zero when ad=0) and rem = 0 (33 bits).
  - bd==0 or n==0: go to FIN directly. Otherwise go to RUN with cnt=n.
- RUN, once per cycle:
  - {rem,quo} <<= 1.
  - If rem >= {1'b0,bd}, set rem -= bd and quo[0] = 1.
  - cnt -= 1; when cnt reaches 0, go to FIN on the same edge.
  - rem is 33 bits wide; the compare is 33-bit unsigned.
- FIN (one cycle):
  - Normal case: q = sign_q ? -quo : quo; r = sign_r ? -rem[31:0] : rem[31:0].
  - Divide-by-zero: q = DIV0_Q; r = dividend or 0 per DIV0_R_IS_DIVIDEND.
  - Outputs are registered so they are valid in the done cycle; done=1; next state IDLE.
- Latency: done is high in the cycle after edge E0+n, i.e. n+1 cycles after acceptance. Divide-by-zero and zero dividend take 1 cycle.
- busy=1 in RUN and FIN. busy falls with done.
- q/r hold their value until the next FIN. done is 0 outside FIN.
- start while busy is ignored, with no queueing.
- start in the FIN cycle is ignored. The pipeline re-issues it the next cycle.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (wraps naturally). No trap.
- Remainder sign follows the dividend. Quotient truncates toward zero, per MIPS.

Decomposition:
- A shared package holds the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the DIV0 defaults, for reuse by the HI/LO control.
- The single sub-module is the existing _CLZ, instantiated once on ad. Its 32-bit output is truncated to 6 bits.
- The abs/negate logic stays inline.

Test Plan:
- DIVU 100/7: clz(100)=25, n=7 -> done 8 cycles after acceptance; q=14, r=2; busy high for exactly 8 cycles.
- DIV -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; DIV 7/-2 -> q=0xFFFFFFFD, r=1.
- DIV 0x80000000/0xFFFFFFFF -> n=32, done after 33 cycles; q=0x80000000, r=0. DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0, 33 cycles.
- DIVU 5/0 -> done 1 cycle after acceptance; q=0xFFFFFFFF, r=5. DIVU 0/9 -> done after 1 cycle; q=0, r=0.
- Ignored start and mid-op reset:
  - Pulse start with 9/3 at cycle 3 of a 100/7 op -> result still q=14, r=2, and only one done.
  - Drop rstn at cycle 4 of an op -> busy=0, done=0, q=0, r=0 immediately. No done follows. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/clz_div_pkg.sv
// clz_div_pkg
// Shared definitions for the multi-cycle integer divider and the HI/LO
// control that consumes its results.
//   state_t                 : divider FSM encoding (IDLE / RUN / FIN)
//   DIV0_Q_DEFAULT          : quotient returned on divide-by-zero
//   DIV0_R_IS_DIVIDEND_DEF  : 1 -> remainder on divide-by-zero is the dividend,
//                             0 -> remainder is zero
package clz_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [31:0] DIV0_Q_DEFAULT         = 32'hFFFF_FFFF;
    localparam int          DIV0_R_IS_DIVIDEND_DEF = 1;

endpackage

// File: rtl/clz_div_clz.sv
// clz_div_clz
// Count-leading-zeros of a 32-bit word, purely combinational.
//   a     : input word
//   count : number of leading zero bits, 0..32 (32 when a == 0)
module clz_div_clz (
    input  logic [31:0] a,
    output logic [31:0] count
);

    // Scan from the LSB upwards; the highest set bit is the last one to
    // write, so it determines the result.
    always_comb begin
        count = 32'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                count = 32'(31 - i);
            end
        end
    end

endmodule

// File: rtl/clz_div.sv
// clz_div
// Multi-cycle 32-bit divider for DIV / DIVU. The dividend magnitude is
// pre-shifted past its leading zeros so only 32-clz restoring iterations run.
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   start      : request, sampled only while idle
//   is_signed  : 1 = DIV, 0 = DIVU, sampled with start
//   dividend   : sampled with start
//   divisor    : sampled with start
//   busy       : high from the accepting edge until done falls
//   done       : one-cycle pulse, q/r valid from this cycle on
//   q          : quotient (to LO)
//   r          : remainder (to HI)
module clz_div
    import clz_div_pkg::*;
#(
    parameter logic [31:0] DIV0_Q             = DIV0_Q_DEFAULT,
    parameter int          DIV0_R_IS_DIVIDEND = DIV0_R_IS_DIVIDEND_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    state_t      state_reg, state_next;
    logic        sign_q_reg, sign_q_next;
    logic        sign_r_reg, sign_r_next;
    logic [31:0] quo_reg, quo_next;
    logic [32:0] rem_reg, rem_next;
    logic [31:0] bd_reg, bd_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] q_reg, q_next;
    logic [31:0] r_reg, r_next;

    // Operand conditioning on the raw inputs (used only in the accept cycle)
    logic [31:0] ad;
    logic [31:0] bd;
    logic [31:0] clz_full;
    logic [5:0]  clz6;
    logic [5:0]  n;

    assign ad = (is_signed && dividend[31]) ? -dividend : dividend;
    assign bd = (is_signed && divisor[31])  ? -divisor  : divisor;

    clz_div_clz u_clz (
        .a     (ad),
        .count (clz_full)
    );

    // The count never exceeds 32; saturate anyway so the upper bits are
    // accounted for rather than silently dropped.
    assign clz6 = (|clz_full[31:6]) ? 6'd32 : clz_full[5:0];
    assign n    = 6'd32 - clz6;

    // One restoring step: shift {rem,quo} left, subtract if it fits.
    logic [33:0] rem_sh;
    logic        fits;
    logic [32:0] rem_step;
    logic [31:0] quo_step;

    assign rem_sh   = {rem_reg, quo_reg[31]};
    assign fits     = rem_sh >= {2'b00, bd_reg};
    assign rem_step = fits ? 33'(rem_sh - {2'b00, bd_reg}) : rem_sh[32:0];
    assign quo_step = {quo_reg[30:0], fits};

    always_comb begin
        state_next  = state_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        quo_next    = quo_reg;
        rem_next    = rem_reg;
        bd_next     = bd_reg;
        cnt_next    = cnt_reg;
        q_next      = q_reg;
        r_next      = r_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_q_next = is_signed & (dividend[31] ^ divisor[31]);
                    sign_r_next = is_signed & dividend[31];
                    quo_next    = ad << clz6;
                    rem_next    = 33'd0;
                    bd_next     = bd;
                    cnt_next    = n;
                    if (bd == 32'd0) begin
                        state_next = FIN;
                        q_next     = DIV0_Q;
                        r_next     = (DIV0_R_IS_DIVIDEND != 0) ? dividend : 32'd0;
                    end else if (n == 6'd0) begin
                        // Zero dividend: result is 0 remainder 0 regardless of sign.
                        state_next = FIN;
                        q_next     = 32'd0;
                        r_next     = 32'd0;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                quo_next = quo_step;
                rem_next = rem_step;
                cnt_next = cnt_reg - 6'd1;
                if (cnt_reg == 6'd1) begin
                    // Final values are registered on the edge into FIN so
                    // they are already valid while done is high.
                    state_next = FIN;
                    q_next     = sign_q_reg ? -quo_step : quo_step;
                    r_next     = sign_r_reg ? -rem_step[31:0] : rem_step[31:0];
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            quo_reg    <= 32'd0;
            rem_reg    <= 33'd0;
            bd_reg     <= 32'd0;
            cnt_reg    <= 6'd0;
            q_reg      <= 32'd0;
            r_reg      <= 32'd0;
        end else begin
            state_reg  <= state_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            quo_reg    <= quo_next;
            rem_reg    <= rem_next;
            bd_reg     <= bd_next;
            cnt_reg    <= cnt_next;
            q_reg      <= q_next;
            r_reg      <= r_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == FIN);
    assign q    = q_reg;
    assign r    = r_reg;

endmodule

// File: tb/tb_clz_div.sv
// tb_clz_div
// Self-checking bench for clz_div: directed corner cases, ignored start,
// mid-operation reset, and randomized operations against an arithmetic
// reference model.
module tb_clz_div;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;

    int total = 0;
    int bad   = 0;

    clz_div dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer division on 64-bit values,
    // latency = bit length of the dividend magnitude (0 for divide-by-zero).
    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eq, output logic [31:0] er,
                                    output int lat);
        longint x, y;
        logic [31:0] mag;
        lat = 0;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
        end else begin
            x   = sg ? longint'($signed(a)) : longint'({32'd0, a});
            y   = sg ? longint'($signed(b)) : longint'({32'd0, b});
            eq  = 32'(x / y);
            er  = 32'(x % y);
            mag = (sg && a[31]) ? -a : a;
            while (mag != 32'd0) begin
                lat++;
                mag = mag >> 1;
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        int lat, k;
        bit got;
        ref_div(sg, a, b, eq, er, lat);
        start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; got = 0;
        while (k <= 40) begin
            if (done) begin
                got = 1;
                break;
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, got ? 32'(k) : 32'd99, 32'(lat));
        if (got) begin
            chk({tag, "_q"}, q, eq);
            chk({tag, "_r"}, r, er);
            chk({tag, "_busy_done"}, 32'(busy), 32'd1);
            @(posedge clk); #1;
            chk({tag, "_done_fall"}, 32'(done), 32'd0);
            chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        end
        $display("op %s sg=%0d a=%h b=%h q=%h r=%h lat=%0d", tag, sg, a, b, q, r, k);
    endtask

    initial begin
        int ndone;
        logic [31:0] hq, hr, a, b;
        logic sg;

        rstn = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_op("divu_0_9", 1'b0, 32'd0, 32'd9);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);

        // Start pulsed mid-operation must be ignored
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; hq = 32'd0; hr = 32'd0;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                hq = q;
                hr = r;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_q", hq, 32'd14);
        chk("ign_r", hr, 32'd2);
        $display("op ignored_start ndone=%0d q=%h r=%h", ndone, hq, hr);

        // Reset in the middle of an operation
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_q", q, 32'd0);
        chk("mid_rst_r", r, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        $display("op mid_reset ndone_after=%0d", ndone);
        run_op("after_rst", 1'b0, 32'd100, 32'd7);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 255);
                1: a = -$urandom_range(1, 1000);
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2, 3: b = $urandom_range(1, 20);
                4: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op("rnd", sg, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
